// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures a divided clock sampled in the clk domain
// and checks its period against the expected division ratio.
module clk_ratio_monitor #(
  parameter int CNT_W       = 16,
  parameter int EXP_DIV     = 2,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             stuck,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0] EXP_V = (CNT_W+1)'(EXP_DIV);
  localparam logic [CNT_W:0] TOL_V = (CNT_W+1)'(TOL);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_CNT);
  localparam logic [GW:0] LOCK_V = (GW+1)'(LOCK_CNT);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, fall;

  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [CNT_W-1:0] hcnt, hcnt_n;
  logic [CNT_W-1:0] meas;
  logic [CNT_W:0]   meas_x;
  logic [GW-1:0]    good, good_n;
  logic             in_tol;

  logic [CNT_W-1:0] period_n, high_n;
  logic valid_n, locked_n, mism_n, stuck_n, err_n;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign meas = sat_inc(pcnt);

  // synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync[0] <= clk_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync[i] <= sync[i-1];
      s_d <= s;
    end
  end

  // absolute deviation of the measured period from the expected ratio
  always_comb begin
    meas_x = {1'b0, meas};
    if (meas_x >= EXP_V)
      in_tol = (meas_x - EXP_V) <= TOL_V;
    else
      in_tol = (EXP_V - meas_x) <= TOL_V;
  end

  // next state, counters and outputs; en low and timeout override rise
  always_comb begin
    state_n  = state;
    pcnt_n   = pcnt;
    hcnt_n   = hcnt;
    good_n   = good;
    period_n = period;
    high_n   = high_time;
    valid_n  = 1'b0;
    locked_n = locked;
    mism_n   = 1'b0;
    stuck_n  = 1'b0;
    unique case (state)
      IDLE: begin
        pcnt_n   = '0;
        hcnt_n   = '0;
        good_n   = '0;
        locked_n = 1'b0;
        state_n  = ARM;
      end
      ARM, MEASURE: begin
        pcnt_n = rise ? '0 : sat_inc(pcnt);
        hcnt_n = rise ? '0 : (s ? sat_inc(hcnt) : hcnt);
        if (state == MEASURE && fall)
          high_n = sat_inc(hcnt);
        if (pcnt == TO_LAST) begin
          stuck_n  = 1'b1;
          locked_n = 1'b0;
          good_n   = '0;
          pcnt_n   = '0;
          state_n  = ARM;
        end else if (rise) begin
          if (state == ARM) begin
            state_n = MEASURE;
          end else begin
            period_n = meas;
            valid_n  = 1'b1;
            if (in_tol) begin
              good_n   = (good == GMAX) ? good : good + GW'(1);
              locked_n = ({1'b0, good} + (GW+1)'(1)) >= LOCK_V;
            end else begin
              good_n   = '0;
              locked_n = 1'b0;
              mism_n   = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!en) begin
      state_n  = IDLE;
      pcnt_n   = '0;
      hcnt_n   = '0;
      good_n   = '0;
      locked_n = 1'b0;
      period_n = period;
      high_n   = high_time;
      valid_n  = 1'b0;
      mism_n   = 1'b0;
      stuck_n  = 1'b0;
    end
    if (mism_n || stuck_n)
      err_n = 1'b1;
    else if (clr_err)
      err_n = 1'b0;
    else
      err_n = err_sticky;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      hcnt       <= '0;
      good       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      stuck      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      hcnt       <= hcnt_n;
      good       <= good_n;
      period     <= period_n;
      high_time  <= high_n;
      meas_valid <= valid_n;
      locked     <= locked_n;
      mismatch   <= mism_n;
      stuck      <= stuck_n;
      err_sticky <= err_n;
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: scoreboard bench for clk_ratio_monitor with
// three instances (default, tolerance, narrow counters).
module tb_clk_ratio_monitor;

  typedef struct {
    int u;
    int per;
    int hi;
    bit mm;
    bit lk;
  } exp_t;

  logic clk;
  logic rst;
  logic clr_err;
  logic [2:0] en;
  logic [2:0] cin;

  logic [2:0] mv, mm, lk, st, er;
  logic [15:0] pr0, hi0, pr1, hi1;
  logic [3:0]  pr2, hi2;
  logic [15:0] pr [3];
  logic [15:0] hi [3];

  exp_t q[$];
  exp_t me;
  int   ed [3] = '{2, 4, 2};
  int   tl [3] = '{0, 1, 0};
  int   gd [3] = '{0, 0, 0};
  int   lmv [3] = '{0, 0, 0};
  int   cyc = 0;
  int   nst2 = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   clr_pend = 0;
  int   t1, k;

  assign pr[0] = pr0;
  assign hi[0] = hi0;
  assign pr[1] = pr1;
  assign hi[1] = hi1;
  assign pr[2] = {12'b0, pr2};
  assign hi[2] = {12'b0, hi2};

  clk_ratio_monitor u0 (
    .clk(clk), .rst(rst), .en(en[0]), .clk_in(cin[0]),
    .clr_err(clr_err), .period(pr0), .high_time(hi0),
    .meas_valid(mv[0]), .locked(lk[0]), .mismatch(mm[0]),
    .stuck(st[0]), .err_sticky(er[0])
  );

  clk_ratio_monitor #(.EXP_DIV(4), .TOL(1)) u1 (
    .clk(clk), .rst(rst), .en(en[1]), .clk_in(cin[1]),
    .clr_err(clr_err), .period(pr1), .high_time(hi1),
    .meas_valid(mv[1]), .locked(lk[1]), .mismatch(mm[1]),
    .stuck(st[1]), .err_sticky(er[1])
  );

  clk_ratio_monitor #(.CNT_W(4), .TIMEOUT(15)) u2 (
    .clk(clk), .rst(rst), .en(en[2]), .clk_in(cin[2]),
    .clr_err(clr_err), .period(pr2), .high_time(hi2),
    .meas_valid(mv[2]), .locked(lk[2]), .mismatch(mm[2]),
    .stuck(st[2]), .err_sticky(er[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clk_in period on instance u; push = a later rise will measure it
  task automatic per(input int u, input int p, input int h,
                     input bit push, input bit clr = 1'b0,
                     input bit clr_exp = 1'b0);
    exp_t e;
    if (push) begin
      e.u   = u;
      e.per = p;
      e.hi  = h;
      if ((p - ed[u] <= tl[u]) && (ed[u] - p <= tl[u])) begin
        e.mm = 1'b0;
        if (gd[u] < 4) gd[u]++;
        e.lk = (gd[u] >= 4);
      end else begin
        e.mm  = 1'b1;
        gd[u] = 0;
        e.lk  = 1'b0;
      end
      q.push_back(e);
    end
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      cin[u] = (i < h);
      if (i == 0 && clr_err) begin
        clr_err = 1'b0;
        chk("err_clr", er[0], clr_pend);
      end
      if (i == p - 1 && clr) begin
        clr_err  = 1'b1;
        clr_pend = clr_exp;
      end
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (mv[u]) begin
        lmv[u] = cyc;
        if (q.size() == 0) begin
          chk("mv_unexp", q.size(), 1);
        end else begin
          me = q.pop_front();
          chk("mv_unit", u, me.u);
          chk("period", pr[u], me.per);
          chk("high_time", hi[u], me.hi);
          chk("mismatch", mm[u], me.mm);
          chk("locked", lk[u], me.lk);
        end
      end
      if (mm[u]) chk("mm_mv", mv[u], 1);
    end
    if (st[2]) nst2++;
  end

  initial begin
    rst = 1'b1;
    en = '0;
    cin = '0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_period", pr0, 0);
    chk("rst_high", hi0, 0);
    chk("rst_locked", lk[0], 0);
    chk("rst_err", er[0], 0);
    chk("rst_mv", mv[0], 0);
    rst = 1'b0;
    en[0] = 1'b1;

    // ratio 2, then ratio 3 with set-wins clear
    repeat (8) per(0, 2, 1, 1);
    repeat (3) per(0, 3, 1, 1);
    chk("err_set", er[0], 1);
    per(0, 3, 1, 1, 1, 1);
    repeat (2) per(0, 3, 1, 1);
    chk("r3_locked", lk[0], 0);

    // relock, clear err in a quiet cycle
    repeat (6) per(0, 2, 1, 1);
    per(0, 2, 1, 1, 1, 0);
    repeat (2) per(0, 2, 1, 1);
    per(0, 2, 1, 0);
    chk("lock_pre", lk[0], 1);

    // dead input: stuck twice, 64 apart
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!st[0] && k < 200);
    chk("stuck_dly", cyc - lmv[0], 64);
    chk("stuck_lk", lk[0], 0);
    chk("stuck_err", er[0], 1);
    t1 = cyc;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!st[0] && k < 200);
    chk("stuck_rep", cyc - t1, 64);
    gd[0] = 0;

    // restart: first rise re-arms, lock after 4 good
    repeat (5) per(0, 2, 1, 1);
    per(0, 4, 1, 0);
    @(negedge clk);
    chk("lk_pre_en", lk[0], 1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("en_locked", lk[0], 0);
    chk("en_period", pr0, 2);
    chk("en_high", hi0, 1);
    gd[0] = 0;
    en[0] = 1'b1;

    // reset mid-stream
    repeat (5) per(0, 2, 1, 1);
    per(0, 2, 1, 0);
    repeat (2) @(negedge clk);
    chk("lk_pre_rst", lk[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_period", pr0, 0);
    chk("mrst_high", hi0, 0);
    chk("mrst_locked", lk[0], 0);
    chk("mrst_mv", mv[0], 0);
    rst = 1'b0;
    en[0] = 1'b0;

    // tolerance: 4,5,3,4 lock then 6 mismatch
    en[1] = 1'b1;
    @(negedge clk);
    per(1, 4, 2, 1);
    per(1, 5, 2, 1);
    per(1, 3, 1, 1);
    per(1, 4, 2, 1);
    per(1, 6, 3, 1);
    per(1, 4, 2, 0);
    chk("tol_drop", lk[1], 0);
    chk("tol_err", er[1], 1);
    en[1] = 1'b0;

    // narrow counters: timeout before wrap
    en[2] = 1'b1;
    @(negedge clk);
    repeat (3) per(2, 20, 10, 0);
    chk("sat_stuck", nst2 >= 3, 1);
    chk("sat_period", pr[2], 0);
    chk("sat_locked", lk[2], 0);
    en[2] = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
